// File: rtl/system_seq_if.sv
// rtl/system_seq_if.sv - instruction handshake and accumulator control bus for system_seq
interface system_seq_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             instr_valid;
    logic [7:0]       instr;
    logic             instr_ready;
    logic [3:0]       Abus;
    logic             SelB;
    logic             AddAlu;
    logic             LoadAc;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] op_cnt;

    // Instruction source / status consumer side
    modport master (
        output start, instr_valid, instr,
        input  instr_ready, Abus, SelB, AddAlu, LoadAc, busy, done, op_cnt
    );

    // Sequencer side
    modport slave (
        input  start, instr_valid, instr,
        output instr_ready, Abus, SelB, AddAlu, LoadAc, busy, done, op_cnt
    );
endinterface

// File: rtl/system_seq.sv
// rtl/system_seq.sv - instruction sequencer driving accumulator datapath strobes
module system_seq #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    system_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b11;

    state_t           state_q, state_d;
    logic [3:0]       abus_q, abus_d;
    logic             selb_q, selb_d;
    logic             addalu_q, addalu_d;
    logic             loadac_q, loadac_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       rep_q, rep_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] op_cnt_inc;

    logic [1:0] opcode;
    logic [1:0] rep_field;
    logic [3:0] operand;

    assign opcode    = bus.instr[7:6];
    assign rep_field = bus.instr[5:4];
    assign operand   = bus.instr[3:0];

    // Completed-instruction count sticks at all-ones instead of wrapping
    assign op_cnt_inc = (op_cnt_q == {CNT_W{1'b1}}) ? op_cnt_q : op_cnt_q + CNT_W'(1);

    // Next-state and registered-output decode; strobes simply hold through EXEC
    always_comb begin
        state_d  = state_q;
        abus_d   = abus_q;
        selb_d   = selb_q;
        addalu_d = addalu_q;
        loadac_d = loadac_q;
        rep_d    = rep_q;
        op_cnt_d = op_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                selb_d   = 1'b0;
                addalu_d = 1'b0;
                loadac_d = 1'b0;
                if (bus.instr_valid) begin
                    if (opcode == OP_HALT) begin
                        state_d  = HALT;
                        op_cnt_d = op_cnt_inc;
                    end else begin
                        state_d  = EXEC;
                        abus_d   = operand;
                        rep_d    = (opcode == OP_LDI) ? 2'd0 : rep_field;
                        selb_d   = (opcode == OP_LDI);
                        addalu_d = (opcode == OP_ADD);
                        loadac_d = (opcode == OP_LDI) || (opcode == OP_ADD);
                    end
                end
            end
            EXEC: begin
                if (rep_q == 2'd0) begin
                    state_d  = FETCH;
                    selb_d   = 1'b0;
                    addalu_d = 1'b0;
                    loadac_d = 1'b0;
                    op_cnt_d = op_cnt_inc;
                end else begin
                    rep_d = rep_q - 2'd1;
                end
            end
            HALT: begin
                if (bus.start) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == FETCH) || (state_d == EXEC);
        done_d = (state_d == HALT);
    end

    // State and output registers with immediate clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            abus_q   <= 4'd0;
            selb_q   <= 1'b0;
            addalu_q <= 1'b0;
            loadac_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rep_q    <= 2'd0;
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            abus_q   <= abus_d;
            selb_q   <= selb_d;
            addalu_q <= addalu_d;
            loadac_q <= loadac_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rep_q    <= rep_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    assign bus.instr_ready = (state_q == FETCH);
    assign bus.Abus        = abus_q;
    assign bus.SelB        = selb_q;
    assign bus.AddAlu      = addalu_q;
    assign bus.LoadAc      = loadac_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.op_cnt      = op_cnt_q;
endmodule

// File: tb/tb_system_seq.sv
// tb/tb_system_seq.sv - self-checking bench for system_seq
module tb_system_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    system_seq_if #(.CNT_W(8)) bus ();
    system_seq_if #(.CNT_W(2)) bus2 ();

    system_seq #(.CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    system_seq #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] strobes();
        return {bus.SelB, bus.AddAlu, bus.LoadAc};
    endfunction

    // Expected strobe pattern {SelB, AddAlu, LoadAc} for an executing opcode
    function automatic logic [2:0] exp_strobes(input logic [1:0] op);
        case (op)
            2'b00:   return 3'b101;
            2'b01:   return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    // Called at a falling edge with the sequencer in FETCH; returns at a falling edge
    // in FETCH (or HALT for opcode 11) with instr_valid dropped.
    task automatic run_instr(input logic [1:0] op, input logic [1:0] rep, input logic [3:0] opd);
        int n;
        chk("fetch_ready", bus.instr_ready, 1);
        chk("fetch_strobes", strobes(), 0);
        bus.instr_valid = 1'b1;
        bus.instr = {op, rep, opd};
        @(negedge clk);
        if (op == 2'b11) begin
            exp_cnt = sat_inc(exp_cnt, 255);
            chk("halt_done", bus.done, 1);
            chk("halt_busy", bus.busy, 0);
            chk("halt_strobes", strobes(), 0);
            chk("halt_ready", bus.instr_ready, 0);
            chk("halt_op_cnt", bus.op_cnt, exp_cnt);
            bus.instr_valid = 1'b0;
        end else begin
            n = (op == 2'b00) ? 1 : int'(rep) + 1;
            for (int i = 0; i < n; i++) begin
                // Next word offered early and start toggled; both must be ignored in EXEC
                bus.instr = 8'($urandom);
                bus.start = 1'($urandom);
                chk("exec_abus", bus.Abus, opd);
                chk("exec_strobes", strobes(), exp_strobes(op));
                chk("exec_busy", bus.busy, 1);
                chk("exec_done", bus.done, 0);
                chk("exec_ready", bus.instr_ready, 0);
                chk("exec_op_cnt", bus.op_cnt, exp_cnt);
                @(negedge clk);
            end
            exp_cnt = sat_inc(exp_cnt, 255);
            chk("post_ready", bus.instr_ready, 1);
            chk("post_strobes", strobes(), 0);
            chk("post_busy", bus.busy, 1);
            chk("post_abus", bus.Abus, opd);
            chk("post_op_cnt", bus.op_cnt, exp_cnt);
            bus.instr_valid = 1'b0;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int exp2[5];
        logic [1:0] rop;
        exp2 = '{1, 2, 3, 3, 3};

        bus.start = 1'b0; bus.instr_valid = 1'b0; bus.instr = 8'h00;
        bus2.start = 1'b0; bus2.instr_valid = 1'b0; bus2.instr = 8'h00;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_abus", bus.Abus, 0);
        chk("rst_strobes", strobes(), 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.instr_ready, 0);
        chk("rst_op_cnt", bus.op_cnt, 0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_ready", bus.instr_ready, 0);
        chk("idle_busy", bus.busy, 0);

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_ready", bus.instr_ready, 1);
        chk("start_busy", bus.busy, 1);
        chk("start_done", bus.done, 0);

        run_instr(2'b00, 2'b10, 4'hF);
        run_instr(2'b01, 2'b11, 4'h6);
        run_instr(2'b10, 2'b10, 4'h3);

        for (int k = 0; k < 12; k++) begin
            rop = 2'($urandom_range(0, 2));
            run_instr(rop, 2'($urandom), 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("gap_ready", bus.instr_ready, 1);
                chk("gap_strobes", strobes(), 0);
            end
        end

        run_instr(2'b11, 2'($urandom), 4'($urandom));
        @(negedge clk);
        @(negedge clk);
        chk("halt_hold_done", bus.done, 1);
        chk("halt_hold_ready", bus.instr_ready, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("resume_done", bus.done, 0);
        chk("resume_ready", bus.instr_ready, 1);
        chk("resume_busy", bus.busy, 1);
        chk("resume_op_cnt", bus.op_cnt, exp_cnt);

        bus.instr_valid = 1'b1;
        bus.instr = {2'b01, 2'b11, 4'h6};
        @(negedge clk);
        chk("abort_c1_strobes", strobes(), 3'b011);
        @(negedge clk);
        chk("abort_c2_strobes", strobes(), 3'b011);
        #2 rst = 1'b1;
        #1;
        chk("abort_abus", bus.Abus, 0);
        chk("abort_strobes", strobes(), 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_ready", bus.instr_ready, 0);
        chk("abort_op_cnt", bus.op_cnt, 0);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        chk("after_rst_ready", bus.instr_ready, 0);
        chk("after_rst_busy", bus.busy, 0);
        chk("after_rst_strobes", strobes(), 0);
        chk("after_rst_op_cnt", bus.op_cnt, 0);

        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        chk("w2_ready", bus2.instr_ready, 1);
        for (int k = 0; k < 5; k++) begin
            bus2.instr_valid = 1'b1;
            bus2.instr = {2'b00, 2'($urandom), 4'($urandom)};
            @(negedge clk);
            chk("w2_strobes", {bus2.SelB, bus2.AddAlu, bus2.LoadAc}, 3'b101);
            @(negedge clk);
            chk("w2_op_cnt", bus2.op_cnt, exp2[k]);
        end
        bus2.instr_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/system_seq.md
SYSTEM_SEQ -- requirements
Module: system_seq

Interface
- REQ-001: The module SHALL have parameter CNT_W, default 8, giving the width of the executed-instruction counter.
- REQ-002: The module SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: The module SHALL have input rst, 1 bit: reset, asynchronous and active-high.
- REQ-004: The module SHALL have input start, 1 bit: level-sampled request to begin or resume fetching.
- REQ-005: The module SHALL have input instr_valid, 1 bit: an instruction word is offered.
- REQ-006: The module SHALL have input instr, 8 bits: [7:6] opcode, [5:4] repeat count, [3:0] operand.
- REQ-007: The module SHALL have output instr_ready, 1 bit: the sequencer accepts an instruction this cycle.
- REQ-008: The module SHALL have output Abus, 4 bits: operand bus to the accumulator datapath.
- REQ-009: The module SHALL have outputs SelB, AddAlu and LoadAc, 1 bit each: control strobes to the accumulator datapath.
- REQ-010: The module SHALL have output busy, 1 bit: high while in FETCH or EXEC.
- REQ-011: The module SHALL have output done, 1 bit: high while in HALT.
- REQ-012: The module SHALL have output op_cnt, CNT_W bits: number of completed instructions, saturating.

Function
- REQ-013: The block SHALL implement FSM states IDLE, FETCH, EXEC and HALT; all outputs are registered, except instr_ready, which is decoded from the state.
- REQ-014: IDLE SHALL go to FETCH on the first rising edge with start=1; otherwise it stays in IDLE.
- REQ-015: In FETCH, instr_ready SHALL be 1, and an instruction SHALL be accepted only on an edge where instr_valid=1 and instr_ready=1.
- REQ-016: On acceptance of opcode 11 (HALT), the FSM SHALL enter HALT, op_cnt SHALL increment, and no strobe SHALL be asserted.
- REQ-017: On acceptance of any other opcode, the FSM SHALL enter EXEC, load the repeat counter and latch the operand onto Abus; strobes SHALL appear in the cycle after the handshake edge (1-cycle latency).
- REQ-018: Opcode 00 (LDI) SHALL drive SelB=1, AddAlu=0, LoadAc=1 for exactly 1 cycle, with the repeat field ignored.
- REQ-019: Opcode 01 (ADD) SHALL drive SelB=0, AddAlu=1, LoadAc=1 for (repeat+1) consecutive cycles (1..4), with Abus held constant.
- REQ-020: Opcode 10 (WAIT) SHALL hold SelB=AddAlu=LoadAc=0 for (repeat+1) cycles.
- REQ-021: When the repeat counter reaches 0 in EXEC, the FSM SHALL return to FETCH on the next edge, increment op_cnt, and drive all strobes to 0 in that cycle.
- REQ-022: Back-to-back instructions SHALL cost 1 FETCH cycle minimum between EXEC phases; no strobe SHALL be asserted in FETCH.
- REQ-023: Abus SHALL retain the last latched operand outside EXEC.
- REQ-024: SelB, AddAlu and LoadAc SHALL be 0 in every state except EXEC.
- REQ-025: instr_valid with instr_ready=0 SHALL be ignored; the source holds the word until accepted.
- REQ-026: start SHALL be ignored in FETCH and EXEC.
- REQ-027: In HALT, start=1 SHALL move the FSM to FETCH and clear done on that edge; op_cnt SHALL be kept.
- REQ-028: op_cnt SHALL stop at all-ones and never wrap.
- REQ-029: instr bits not used by the accepted opcode SHALL have no effect.

Reset
- REQ-030: With rst=1, regardless of clk, the block SHALL immediately force state IDLE, Abus=0, SelB=0, AddAlu=0, LoadAc=0, busy=0, done=0, instr_ready=0, op_cnt=0 and repeat counter=0.
- REQ-031: Assertion of rst mid-EXEC SHALL abort the instruction with no further strobes and no op_cnt increment.
- REQ-032: After rst falls, the block SHALL wait in IDLE for start.

Verification
- REQ-033: The bench SHALL cover: reset, start=1, LDI operand 4'hF accepted at edge N -> cycle N+1: Abus=1111, SelB=1, LoadAc=1, AddAlu=0; cycle N+2: strobes 0, FETCH, op_cnt=1.
- REQ-034: The bench SHALL cover: ADD operand 4'h6, repeat=3 -> AddAlu=LoadAc=1, SelB=0, Abus=0110 for exactly 4 cycles, then FETCH, op_cnt incremented by 1.
- REQ-035: The bench SHALL cover: WAIT repeat=2 -> 3 cycles of zero strobes with busy=1; instr_ready=0 throughout, with instr_valid held high and the next word not consumed.
- REQ-036: The bench SHALL cover: HALT accepted -> done=1, busy=0, strobes 0; start=1 then returns to FETCH with done=0 and op_cnt unchanged.
- REQ-037: The bench SHALL cover: rst asserted between clock edges during the 2nd ADD cycle -> all outputs 0 before the next edge, state IDLE, op_cnt=0.
- REQ-038: The bench SHALL cover: CNT_W=2 with 5 LDI instructions -> op_cnt reads 1,2,3,3,3.
